// File: rtl/exp3_unidade_controle.sv
// rtl/exp3_unidade_controle.sv - Moore control unit sequencing one exp3 game round
//
// Purpose:
//   Drives the exp3 datapath (address counter, switch register, sync ROM,
//   comparator) through a round: clear, wait for a play, latch the switches,
//   compare against memory, advance the address. The round ends in a win
//   after the 16th correct entry, a loss on the first mismatch, or a timeout
//   when a play takes too long.
//
// Parameters:
//   TIMEOUT_CYCLES  clock cycles allowed in ESPERA before timing out (>= 2)
//   TW              width of the internal timeout counter
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   asynchronous reset, active-low
//   iniciar             in   start / restart a round (level)
//   jogada              in   play strobe, rising edge counts
//   chavesIgualMemoria  in   comparator result (register == ROM)
//   fimC                in   counter rco, 1 at address 15
//   zeraC               out  clear address counter
//   contaC              out  increment address counter
//   zeraR               out  clear switch register
//   registraR           out  load switch register
//   pronto              out  round finished (any end state)
//   acertou             out  round won
//   errou               out  round lost by mismatch
//   timeout             out  round lost by timeout
//   db_estado           out  current state code (debug)

module exp3_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // State codes double as the debug display value.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } t_estado;

    t_estado         r_estado;
    t_estado         w_proximo;
    logic            r_jogada_d;
    logic [TW-1:0]   r_timer;
    logic            w_play_edge;
    logic            w_timer_fim;

    // A held jogada produces a single edge; the delayed copy updates every
    // cycle regardless of state, so an edge seen outside ESPERA is consumed
    // and never replayed later.
    assign w_play_edge = jogada & ~r_jogada_d;
    assign w_timer_fim = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= INICIAL;
            r_jogada_d <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_estado   <= w_proximo;
            r_jogada_d <= jogada;
            // Timer only runs while waiting for a play; any other state
            // rearms it, so each play gets the full window.
            if (r_estado == ESPERA) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL: begin
                if (iniciar) begin
                    w_proximo = PREPARACAO;
                end
            end
            PREPARACAO: begin
                w_proximo = ESPERA;
            end
            ESPERA: begin
                // A play arriving on the last timer cycle still counts.
                if (w_play_edge) begin
                    w_proximo = REGISTRA;
                end else if (w_timer_fim) begin
                    w_proximo = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                w_proximo = COMPARACAO;
            end
            COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    w_proximo = FIM_ERROU;
                end else if (fimC) begin
                    w_proximo = FIM_ACERTOU;
                end else begin
                    w_proximo = PROXIMO;
                end
            end
            PROXIMO: begin
                w_proximo = ESPERA;
            end
            FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU: begin
                if (iniciar) begin
                    w_proximo = PREPARACAO;
                end
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (r_estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA: begin
                registraR = 1'b1;
            end
            PROXIMO: begin
                contaC = 1'b1;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = r_estado;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// tb/tb_exp3_unidade_controle.sv - self-checking bench for exp3_unidade_controle

module tb_exp3_unidade_controle;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    exp3_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       ini;
        logic       jog;
        logic       igual;
        logic       fim;
        logic [3:0] st;
    } vec_t;

    vec_t       tbl [22];
    logic [3:0] exp_q [$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         n_reg  = 0;
    int         n_cnt  = 0;

    // Pulse counters; each state lasts one full cycle, so sampling mid-cycle
    // counts one per state visit.
    always @(negedge clock) begin
        if (registraR) n_reg++;
        if (contaC)    n_cnt++;
    end

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [7:0] exp_outs(input logic [3:0] st);
        case (st)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hD:    return 8'b0000_1001;
            4'hE:    return 8'b0000_1010;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check(input string name);
        logic [3:0] e;
        logic [7:0] eo;
        logic [7:0] ao;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e  = exp_q.pop_front();
            eo = exp_outs(e);
            ao = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
            if (db_estado !== e || ao !== eo) begin
                n_miss++;
                $display("FAIL %s: estado=%h outs=%b, expected estado=%h outs=%b",
                         name, db_estado, ao, e, eo);
            end
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic step(input string name, input logic ini, input logic jog,
                        input logic igual, input logic fim, input logic [3:0] st);
        @(negedge clock);
        iniciar            = ini;
        jogada             = jog;
        chavesIgualMemoria = igual;
        fimC               = fim;
        exp_q.push_back(st);
        @(posedge clock);
        #1;
        check(name);
    endtask

    int b_reg;
    int b_cnt;

    initial begin
        // inputs applied during current state -> expected next state
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h5};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h6};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hE};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hE};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1};

        reset = 1'b0; iniciar = 1'b0; jogada = 1'b0;
        chavesIgualMemoria = 1'b0; fimC = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(4'h0);
        check("reset_state");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].ini, tbl[i].jog, tbl[i].igual,
                 tbl[i].fim, tbl[i].st);
        end

        // full win: 16 matching plays, 3 idle cycles each
        step("win_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        b_reg = n_reg; b_cnt = n_cnt;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++)
                step($sformatf("win%0d_idle", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
            step($sformatf("win%0d_play", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
            step($sformatf("win%0d_reg", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
            step($sformatf("win%0d_cmp", i), 1'b0, 1'b0, 1'b1, (i == 15),
                 (i == 15) ? 4'hA : 4'h6);
            if (i < 15)
                step($sformatf("win%0d_next", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        end
        step("win_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
        check_cnt("win_registraR_pulses", n_reg - b_reg, 16);
        check_cnt("win_contaC_pulses", n_cnt - b_cnt, 15);

        // mismatch on 4th play
        step("mis_start", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("mis_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        b_cnt = n_cnt;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("mis%0d_idle", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
            step($sformatf("mis%0d_play", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
            step($sformatf("mis%0d_reg", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
            step($sformatf("mis%0d_cmp", i), 1'b0, 1'b0, (i < 3), 1'b0,
                 (i < 3) ? 4'h6 : 4'hE);
            if (i < 3)
                step($sformatf("mis%0d_next", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        end
        step("mis_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);
        check_cnt("mis_contaC_pulses", n_cnt - b_cnt, 3);

        // restart from FIM_ERROU, iniciar ignored in ESPERA
        step("rst_start", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("rst_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step("rst_ini_espera", 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        step("rst_ini_low", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step("rst_play", 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
        step("rst_reg", 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        step("rst_cmp", 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);

        // timeout: exactly 8 cycles in ESPERA
        step("to_start", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("to_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        for (int t = 0; t < 7; t++)
            step($sformatf("to_wait%0d", t), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step("to_expire", 1'b0, 1'b0, 1'b0, 1'b0, 4'hD);
        step("to_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'hD);

        // collision: edge on the last timer cycle wins
        step("col_start", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("col_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        for (int t = 0; t < 7; t++)
            step($sformatf("col_wait%0d", t), 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step("col_play", 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
        step("col_reg", 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        step("col_cmp", 1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
        step("col_next", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);

        // jogada held for 20 cycles -> one registraR
        b_reg = n_reg;
        step("held_play", 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
        step("held_reg", 1'b0, 1'b1, 1'b0, 1'b0, 4'h5);
        step("held_cmp", 1'b0, 1'b1, 1'b1, 1'b0, 4'h6);
        step("held_next", 1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
        for (int t = 0; t < 7; t++)
            step($sformatf("held_wait%0d", t), 1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
        step("held_expire", 1'b0, 1'b1, 1'b0, 1'b0, 4'hD);
        for (int t = 0; t < 8; t++)
            step($sformatf("held_fim%0d", t), 1'b0, 1'b1, 1'b0, 1'b0, 4'hD);
        check_cnt("held_registraR_pulses", n_reg - b_reg, 1);

        // asynchronous reset in REGISTRA
        step("ar_start", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("ar_prep", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step("ar_play", 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
        #2;
        reset = 1'b0;
        exp_q.push_back(4'h0);
        #1;
        check("ar_async");
        @(negedge clock);
        reset   = 1'b1;
        iniciar = 1'b0;
        jogada  = 1'b0;
        step("ar_restart", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        step("ar_prep_once", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);

        check_cnt("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
